// File: rtl/vit_acs_sched.sv
// Viterbi ACS scheduler: sequences path-metric init, per-step butterfly groups,
// ping-pong bank selection, overflow normalisation and traceback start.
module vit_acs_sched #(
    parameter int unsigned NUM_STATES = 64,
    parameter int unsigned PAR        = 4,
    parameter int unsigned MW         = 12,
    parameter int unsigned SW         = 16,
    localparam int unsigned G         = NUM_STATES / (2 * PAR),
    localparam int unsigned GW        = (G > 1) ? $clog2(G) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frm_start,
    input  logic          bm_valid,
    input  logic          bm_last,
    output logic          bm_ready,
    output logic          bm_take,
    input  logic          msb_hit,
    output logic          init_en,
    output logic          acs_en,
    output logic [GW-1:0] bfly_grp,
    output logic          pm_rd_bank,
    output logic          pm_wr_bank,
    output logic          norm_en,
    output logic [SW-1:0] step_cnt,
    output logic          tb_start
);

    if (NUM_STATES < 2 * PAR) begin : g_bad_states
        $error("NUM_STATES must be at least 2*PAR");
    end
    if (MW < 3) begin : g_bad_mw
        $error("MW must leave 2^(MW-2) normalisation headroom");
    end

    typedef enum logic [2:0] {StIdle, StInit, StWait, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grp_q, grp_d;
    logic          rd_bank_q, rd_bank_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          norm_q, norm_d;
    logic          hit_q, hit_d;
    logic          last_q, last_d;
    logic          grp_last;

    assign grp_last = (grp_q == GW'(G - 1));

    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        rd_bank_d = rd_bank_q;
        cnt_d     = cnt_q;
        norm_d    = norm_q;
        hit_d     = hit_q;
        last_d    = last_q;
        init_en   = 1'b0;
        acs_en    = 1'b0;
        bm_ready  = 1'b0;
        bm_take   = 1'b0;
        tb_start  = 1'b0;

        case (state_q)
            StIdle: ;
            StInit: begin
                init_en = 1'b1;
                if (grp_last) begin
                    grp_d     = '0;
                    rd_bank_d = 1'b0;
                    state_d   = StWait;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            StWait: begin
                bm_ready = 1'b1;
                if (bm_valid && !frm_start) begin
                    bm_take = 1'b1;
                    last_d  = bm_last;
                    grp_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acs_en = 1'b1;
                hit_d  = hit_q | msb_hit;
                if (grp_last) begin
                    // Hits seen during this step normalise the reads of the next one.
                    norm_d    = hit_q | msb_hit;
                    hit_d     = 1'b0;
                    rd_bank_d = ~rd_bank_q;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + SW'(1);
                    end
                    grp_d   = '0;
                    state_d = last_q ? StDone : StWait;
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end
            StDone: begin
                tb_start = !frm_start;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new frame overrides whatever the current state was doing.
        if (frm_start) begin
            state_d   = StInit;
            grp_d     = '0;
            rd_bank_d = 1'b1;
            cnt_d     = '0;
            norm_d    = 1'b0;
            hit_d     = 1'b0;
            last_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grp_q     <= '0;
            rd_bank_q <= 1'b0;
            cnt_q     <= '0;
            norm_q    <= 1'b0;
            hit_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            rd_bank_q <= rd_bank_d;
            cnt_q     <= cnt_d;
            norm_q    <= norm_d;
            hit_q     <= hit_d;
            last_q    <= last_d;
        end
    end

    assign bfly_grp   = grp_q;
    assign pm_rd_bank = rd_bank_q;
    assign pm_wr_bank = ~rd_bank_q;
    assign step_cnt   = cnt_q;
    assign norm_en    = acs_en & norm_q;

endmodule

// File: tb/tb_vit_acs_sched.sv
// Scoreboard bench for vit_acs_sched: randomized frames against a step-level model,
// plus a G=1 instance with a narrow step counter for throughput and saturation.
module tb_vit_acs_sched;

    localparam int unsigned G   = 8;
    localparam int unsigned GW  = 3;
    localparam int unsigned SW  = 16;
    localparam int unsigned SW2 = 4;

    localparam int K_INIT = 8;
    localparam int K_ACS  = 4;
    localparam int K_TAKE = 2;
    localparam int K_TB   = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          frm_start, bm_valid, bm_last, msb_hit;
    logic          bm_ready, bm_take, init_en, acs_en, pm_rd_bank, pm_wr_bank, norm_en, tb_start;
    logic [GW-1:0] bfly_grp;
    logic [SW-1:0] step_cnt;

    logic           frm_start2, bm_valid2, bm_last2, msb_hit2;
    logic           bm_ready2, bm_take2, init_en2, acs_en2, pm_rd_bank2, pm_wr_bank2;
    logic           norm_en2, tb_start2;
    logic [0:0]     bfly_grp2;
    logic [SW2-1:0] step_cnt2;

    vit_acs_sched #(.NUM_STATES(64), .PAR(4), .MW(12), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .bm_valid(bm_valid),
        .bm_last(bm_last), .bm_ready(bm_ready), .bm_take(bm_take), .msb_hit(msb_hit),
        .init_en(init_en), .acs_en(acs_en), .bfly_grp(bfly_grp), .pm_rd_bank(pm_rd_bank),
        .pm_wr_bank(pm_wr_bank), .norm_en(norm_en), .step_cnt(step_cnt), .tb_start(tb_start)
    );

    vit_acs_sched #(.NUM_STATES(16), .PAR(8), .MW(12), .SW(SW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .frm_start(frm_start2), .bm_valid(bm_valid2),
        .bm_last(bm_last2), .bm_ready(bm_ready2), .bm_take(bm_take2), .msb_hit(msb_hit2),
        .init_en(init_en2), .acs_en(acs_en2), .bfly_grp(bfly_grp2), .pm_rd_bank(pm_rd_bank2),
        .pm_wr_bank(pm_wr_bank2), .norm_en(norm_en2), .step_cnt(step_cnt2),
        .tb_start(tb_start2)
    );

    typedef struct {
        int kind;
        int grp;
        bit rd;
        bit norm;
        int cnt;
        bit rdy;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc_n = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  d2_done = 1'b0;
    bit  rand_hit = 1'b1;
    int  dh_step = -1;
    int  dh_grp = -1;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(int kind, int grp, bit rd, bit norm, int cnt, bit rdy);
        ev_t e;
        e.kind = kind; e.grp = grp; e.rd = rd; e.norm = norm;
        e.cnt = cnt; e.rdy = rdy; e.cyc = cyc_n;
        exp_q.push_back(e);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: any DUT activity pops the next expected event and is compared in full.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            int  kind;
            bit  ok;
            ev_t e;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc_n) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event: got nothing at cycle %0d, want kind=%0h grp=%0d",
                         e.cyc, e.kind, e.grp);
            end
            kind = {init_en, acs_en, bm_take, tb_start};
            if (kind != 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0h grp=%0d at cycle %0d, want none",
                             kind, bfly_grp, cyc_n);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (kind == e.kind) && (cyc_n == e.cyc) && (pm_rd_bank == e.rd) &&
                         (pm_wr_bank == !e.rd) && (int'(step_cnt) == e.cnt) &&
                         (bm_ready == e.rdy);
                    if (e.kind == K_INIT || e.kind == K_ACS) ok &= (int'(bfly_grp) == e.grp);
                    if (e.kind == K_ACS) ok &= (norm_en == e.norm);
                    if (!ok) begin
                        errors++;
                        $display({"FAIL event: got cyc=%0d kind=%0h grp=%0d rd=%0b wr=%0b norm=%0b ",
                                  "cnt=%0d rdy=%0b, want cyc=%0d kind=%0h grp=%0d rd=%0b norm=%0b ",
                                  "cnt=%0d rdy=%0b"},
                                 cyc_n, kind, bfly_grp, pm_rd_bank, pm_wr_bank, norm_en,
                                 step_cnt, bm_ready, e.cyc, e.kind, e.grp, e.rd, e.norm,
                                 e.cnt, e.rdy);
                    end
                end
            end
        end
    end

    // One frame of nsteps; optional abort at (ab_step, ab_grp), ab_grp<0 aborts in WAIT.
    task automatic frame(input int nsteps, input int ab_step, input int ab_grp,
                         input bit skip_start, output bit aborted);
        bit norm, hit, h;
        aborted = 1'b0;
        if (!skip_start) begin
            frm_start = 1'b1; bm_valid = rb(); bm_last = rb(); msb_hit = rb();
            cyc();
        end
        frm_start = 1'b0;
        for (int g = 0; g < G; g++) begin
            push(K_INIT, g, 1'b1, 1'b0, 0, 1'b0);
            bm_valid = rb(); bm_last = rb(); msb_hit = rb();
            cyc();
        end
        norm = 1'b0;
        for (int k = 0; k < nsteps; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                bm_valid = 1'b0; bm_last = rb(); msb_hit = rb();
                cyc();
            end
            if (k == ab_step && ab_grp < 0) begin
                frm_start = 1'b1; bm_valid = 1'b1; bm_last = rb();
                cyc();
                aborted = 1'b1;
                return;
            end
            bm_valid = 1'b1; bm_last = (k == nsteps - 1); msb_hit = rb();
            push(K_TAKE, 0, 1'(k % 2), 1'b0, k, 1'b1);
            cyc();
            hit = 1'b0;
            for (int g = 0; g < G; g++) begin
                bm_valid = rb(); bm_last = rb();
                h = rand_hit ? ($urandom_range(0, 7) == 0) : (k == dh_step && g == dh_grp);
                msb_hit = h;
                push(K_ACS, g, 1'(k % 2), norm, k, 1'b0);
                if (k == ab_step && g == ab_grp) begin
                    frm_start = 1'b1;
                    cyc();
                    aborted = 1'b1;
                    return;
                end
                hit |= h;
                cyc();
            end
            norm = hit;
        end
        bm_valid = rb(); bm_last = rb(); msb_hit = rb();
        push(K_TB, 0, 1'(nsteps % 2), 1'b0, nsteps, 1'b0);
        cyc();
        repeat (2) begin
            bm_valid = rb(); bm_last = rb(); msb_hit = rb();
            cyc();
        end
    endtask

    // G=1 instance: one step every two cycles, narrow counter saturates at 15.
    initial begin
        frm_start2 = 1'b0; bm_valid2 = 1'b0; bm_last2 = 1'b0; msb_hit2 = 1'b0;
        wait (rst_n === 1'b1);
        cyc();
        frm_start2 = 1'b1; bm_valid2 = 1'b1;
        for (int c = 0; c < 45; c++) begin
            bit e_init, e_take, e_acs, e_rd;
            int e_cnt, done_steps;
            if (c == 1) frm_start2 = 1'b0;
            @(negedge clk);
            done_steps = (c < 3) ? 0 : (c - 2) / 2;
            e_init = (c == 1);
            e_take = (c >= 2) && (c % 2 == 0);
            e_acs  = (c >= 3) && (c % 2 == 1);
            e_cnt  = (done_steps > 15) ? 15 : done_steps;
            e_rd   = (c == 0) ? 1'b0 : (c == 1) ? 1'b1 : 1'(done_steps % 2);
            checks++;
            if (init_en2 != e_init || bm_take2 != e_take || bm_ready2 != e_take ||
                acs_en2 != e_acs || int'(step_cnt2) != e_cnt || pm_rd_bank2 != e_rd ||
                pm_wr_bank2 != !e_rd || tb_start2 != 1'b0) begin
                errors++;
                $display({"FAIL g1_cycle%0d: got init=%0b take=%0b rdy=%0b acs=%0b cnt=%0d rd=%0b ",
                          "wr=%0b tb=%0b, want init=%0b take=%0b acs=%0b cnt=%0d rd=%0b"},
                         c, init_en2, bm_take2, bm_ready2, acs_en2, step_cnt2, pm_rd_bank2,
                         pm_wr_bank2, tb_start2, e_init, e_take, e_acs, e_cnt, e_rd);
            end
            @(posedge clk);
            #1;
        end
        d2_done = 1'b1;
    end

    initial begin
        bit ab;
        int n, as, ag;
        frm_start = 1'b0; bm_valid = 1'b0; bm_last = 1'b0; msb_hit = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({init_en, acs_en, bm_ready, bm_take, tb_start, norm_en, pm_rd_bank, pm_wr_bank,
             bfly_grp, step_cnt} != {8'b0000_0001, {GW{1'b0}}, {SW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_outputs: got init=%0b acs=%0b rdy=%0b rd=%0b wr=%0b cnt=%0d, %s",
                     init_en, acs_en, bm_ready, pm_rd_bank, pm_wr_bank, step_cnt,
                     "want all zero with wr=1");
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        mon_en = 1'b1;

        frame(3, -1, 0, 1'b0, ab);
        frame(5, 3, 3, 1'b0, ab);
        frame(4, -1, 0, 1'b1, ab);
        rand_hit = 1'b0; dh_step = 1; dh_grp = 5;
        frame(4, -1, 0, 1'b0, ab);
        rand_hit = 1'b1;
        frame(6, 2, -1, 1'b0, ab);
        frame(3, -1, 0, 1'b1, ab);
        for (int i = 0; i < 8; i++) begin
            n  = $urandom_range(1, 6);
            as = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            ag = $urandom_range(0, G) - 1;
            frame(n, as, ag, ab, ab);
        end
        if (ab) frame(2, -1, 0, 1'b1, ab);

        repeat (4) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d events outstanding, want 0", exp_q.size());
        end
        for (int i = 0; i < 200 && !d2_done; i++) cyc();
        checks++;
        if (!d2_done) begin
            errors++;
            $display("FAIL g1_timeout: got unfinished, want finished");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
